// File: rtl/cruise_speed_controller.sv
// Cruise-control sequencer: target latch/adjust, hysteretic speed compare, stale-feed fault.
// Optional feature: define CRUISE_RESUME_EN to enable resume and keep the target across disengage.
module cruise_speed_controller #(
  parameter logic [7:0] MIN_SPEED = 8'd30,
  parameter logic [7:0] MAX_SPEED = 8'd180,
  parameter logic [7:0] STEP      = 8'd5,
  parameter logic [7:0] HYST      = 8'd2,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic       set_btn,
  input  logic       resume_btn,
  input  logic       cancel_btn,
  input  logic       brake,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [7:0] speed,
  input  logic       speed_valid,
  output logic       throttle_up,
  output logic       throttle_dn,
  output logic       cruise_active,
  output logic [7:0] target_speed,
  output logic       target_valid,
  output logic       fault,
  output logic [2:0] state
);

`ifdef CRUISE_RESUME_EN
  localparam bit RESUME_EN = 1'b1;
`else
  localparam bit RESUME_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_STBY = 3'd1, S_HOLD = 3'd2, S_ACCEL = 3'd3, S_DECEL = 3'd4
  } st_e;

  typedef struct packed {
    logic set;
    logic resume;
    logic inc;
    logic dec;
  } btn_t;

  st_e        state_q, state_nxt;
  btn_t       btn_now, btn_q, btn_rise;
  logic [7:0] tgt_q, tgt_nxt;
  logic       tv_q, tv_nxt, flt_q, flt_nxt;
  logic [7:0] cnt_q, cnt_nxt;

  logic [8:0] spd9, tgt9, inc_sum;
  logic       engaged, set_ok, resume_ok, adj_inc, adj_dec, timeout_hit, disengage;
  logic       cmp_lo, cmp_hi;

  assign btn_now  = '{set: set_btn, resume: resume_btn, inc: inc_btn, dec: dec_btn};
  assign btn_rise = btn_now & ~btn_q;

  assign spd9    = {1'b0, speed};
  assign tgt9    = {1'b0, tgt_q};
  assign inc_sum = tgt9 + {1'b0, STEP};
  assign engaged = (state_q == S_HOLD) || (state_q == S_ACCEL) || (state_q == S_DECEL);

  assign set_ok    = btn_rise.set && speed_valid && !brake &&
                     (speed >= MIN_SPEED) && (speed <= MAX_SPEED);
  assign resume_ok = RESUME_EN && btn_rise.resume && tv_q && !brake;
  assign adj_inc   = btn_rise.inc && !btn_rise.dec;
  assign adj_dec   = btn_rise.dec && !btn_rise.inc;
  // Fires on the cycle whose increment would bring the counter to TIMEOUT.
  assign timeout_hit = engaged && !speed_valid && (cnt_q == TIMEOUT - 8'd1);
  assign disengage   = brake || cancel_btn || timeout_hit;

  assign cmp_lo = (spd9 + {1'b0, HYST}) < tgt9;
  assign cmp_hi = spd9 > (tgt9 + {1'b0, HYST});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_OFF;
      btn_q         <= '0;
      tgt_q         <= '0;
      tv_q          <= 1'b0;
      flt_q         <= 1'b0;
      cnt_q         <= '0;
      throttle_up   <= 1'b0;
      throttle_dn   <= 1'b0;
      cruise_active <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      btn_q         <= btn_now;
      tgt_q         <= tgt_nxt;
      tv_q          <= tv_nxt;
      flt_q         <= flt_nxt;
      cnt_q         <= cnt_nxt;
      throttle_up   <= (state_nxt == S_ACCEL);
      throttle_dn   <= (state_nxt == S_DECEL);
      cruise_active <= (state_nxt == S_HOLD) || (state_nxt == S_ACCEL) || (state_nxt == S_DECEL);
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (!power_on) begin
      state_nxt = S_OFF;
    end else begin
      case (state_q)
        S_OFF:  state_nxt = S_STBY;
        S_STBY: if (set_ok || resume_ok) state_nxt = S_HOLD;
        S_HOLD, S_ACCEL, S_DECEL: begin
          if (disengage)        state_nxt = S_STBY;
          else if (set_ok)      state_nxt = S_HOLD;
          else if (speed_valid) begin
            case (state_q)
              S_HOLD:  state_nxt = cmp_lo ? S_ACCEL : (cmp_hi ? S_DECEL : S_HOLD);
              S_ACCEL: if (spd9 >= tgt9) state_nxt = S_HOLD;
              default: if (spd9 <= tgt9) state_nxt = S_HOLD;
            endcase
          end
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // Compare above uses tgt_q, so a same-cycle adjust only affects the next sample.
  always_comb begin
    tgt_nxt = tgt_q;
    tv_nxt  = tv_q;
    flt_nxt = flt_q;
    cnt_nxt = cnt_q;
    if (!power_on) begin
      tgt_nxt = '0;
      tv_nxt  = 1'b0;
      flt_nxt = 1'b0;
      cnt_nxt = '0;
    end else begin
      case (state_q)
        S_STBY: begin
          cnt_nxt = '0;
          if (set_ok) begin
            tgt_nxt = speed;
            tv_nxt  = 1'b1;
            flt_nxt = 1'b0;
          end
        end
        S_HOLD, S_ACCEL, S_DECEL: begin
          if (disengage) begin
            cnt_nxt = '0;
            if (!brake && !cancel_btn) flt_nxt = 1'b1;
            if (!RESUME_EN) begin
              tgt_nxt = '0;
              tv_nxt  = 1'b0;
            end
          end else begin
            if (speed_valid)           cnt_nxt = '0;
            else if (cnt_q != TIMEOUT) cnt_nxt = cnt_q + 8'd1;
            if (set_ok)
              tgt_nxt = speed;
            else if (adj_inc)
              tgt_nxt = (inc_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : inc_sum[7:0];
            else if (adj_dec)
              tgt_nxt = (tgt9 < ({1'b0, MIN_SPEED} + {1'b0, STEP})) ? MIN_SPEED : (tgt_q - STEP);
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  assign target_speed = tgt_q;
  assign target_valid = tv_q;
  assign fault        = flt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cruise_speed_controller.sv
// Directed bench for cruise_speed_controller; expectations queued per cycle, checked by a monitor.
module tb_cruise_speed_controller;

`ifdef CRUISE_RESUME_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, power_on, set_btn, resume_btn, cancel_btn, brake, inc_btn, dec_btn;
  logic [7:0] speed;
  logic       speed_valid;
  logic       throttle_up, throttle_dn, cruise_active, target_valid, fault;
  logic [7:0] target_speed;
  logic [2:0] state;

  cruise_speed_controller dut (
    .clk(clk), .rst_n(rst_n), .power_on(power_on), .set_btn(set_btn),
    .resume_btn(resume_btn), .cancel_btn(cancel_btn), .brake(brake),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .speed(speed), .speed_valid(speed_valid),
    .throttle_up(throttle_up), .throttle_dn(throttle_dn), .cruise_active(cruise_active),
    .target_speed(target_speed), .target_valid(target_valid), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      name;
    logic [2:0] st;
    logic [7:0] tgt;
    logic       tv, flt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;

  logic [2:0] e_st;
  logic [7:0] e_tgt;
  logic       e_tv, e_flt;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation that falls due on this negedge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic xu, xd, xa;
      e  = q.pop_front();
      xu = (e.st == 3'd3);
      xd = (e.st == 3'd4);
      xa = (e.st >= 3'd2) && (e.st <= 3'd4);
      checks++;
      if (e.due != cyc || state !== e.st || throttle_up !== xu || throttle_dn !== xd ||
          cruise_active !== xa || target_speed !== e.tgt || target_valid !== e.tv || fault !== e.flt) begin
        errors++;
        $display("FAIL %s cyc=%0d: got st=%0d up=%b dn=%b act=%b tgt=%0d tv=%b flt=%b, want st=%0d up=%b dn=%b act=%b tgt=%0d tv=%b flt=%b",
                 e.name, cyc, state, throttle_up, throttle_dn, cruise_active, target_speed,
                 target_valid, fault, e.st, xu, xd, xa, e.tgt, e.tv, e.flt);
      end
    end
  end

  task automatic push(input string nm, input int due);
    exp_t e;
    e.due = due; e.name = nm; e.st = e_st; e.tgt = e_tgt; e.tv = e_tv; e.flt = e_flt;
    q.push_back(e);
  endtask

  // One clock: inputs already driven, expectation for after the next posedge queued; strobes then dropped.
  task automatic tick(input string nm);
    push(nm, cyc + 1);
    @(negedge clk);
    speed_valid = 1'b0; set_btn = 1'b0; resume_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
  endtask

  task automatic sample(input logic [7:0] s, input string nm);
    speed = s; speed_valid = 1'b1;
    tick(nm);
  endtask

  task automatic latch(input logic [7:0] s, input string nm);
    speed = s; speed_valid = 1'b1; set_btn = 1'b1;
    e_st = 3'd2; e_tgt = s; e_tv = 1'b1; e_flt = 1'b0;
    tick(nm);
    tick({nm, "_idle"});
  endtask

  task automatic drop_target();
    e_st = 3'd1;
    if (!RES) begin e_tgt = 8'd0; e_tv = 1'b0; end
  endtask

  initial begin
    rst_n = 1'b0; power_on = 1'b0; set_btn = 1'b0; resume_btn = 1'b0; cancel_btn = 1'b0;
    brake = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0; speed = 8'd0; speed_valid = 1'b0;
    e_st = 3'd0; e_tgt = 8'd0; e_tv = 1'b0; e_flt = 1'b0;
    repeat (2) @(negedge clk);
    power_on = 1'b1;
    tick("reset");
    rst_n = 1'b1; power_on = 1'b0;
    tick("off_hold");

    power_on = 1'b1; e_st = 3'd1;
    tick("power_on");
    latch(8'd100, "set100");

    e_st = 3'd3; sample(8'd97, "accel97");
    sample(8'd99, "stay_accel99");
    e_st = 3'd2; sample(8'd100, "hold100");

    sample(8'd98, "hold98_edge");
    sample(8'd102, "hold102_edge");
    e_st = 3'd4; sample(8'd103, "decel103");
    e_st = 3'd2; sample(8'd100, "hold_from_decel");

    latch(8'd178, "set178");
    inc_btn = 1'b1; e_tgt = 8'd180; tick("inc_to_max");
    tick("inc_idle");
    inc_btn = 1'b1; tick("inc_sat");
    tick("inc_idle2");
    latch(8'd32, "set32");
    dec_btn = 1'b1; e_tgt = 8'd30; tick("dec_to_min");
    tick("dec_idle");
    inc_btn = 1'b1; dec_btn = 1'b1; tick("inc_dec_both");
    tick("both_idle");
    inc_btn = 1'b1; e_st = 3'd4; e_tgt = 8'd35; sample(8'd33, "cmp_before_adjust");
    e_st = 3'd2; sample(8'd35, "hold_new_target");

    latch(8'd100, "set100b");
    brake = 1'b1; drop_target(); tick("brake");
    brake = 1'b0; tick("brake_release");
    resume_btn = 1'b1;
    if (RES) e_st = 3'd2;
    tick("resume");
    tick("resume_idle");
    latch(8'd60, "set60");
    cancel_btn = 1'b1; drop_target(); tick("cancel");
    cancel_btn = 1'b0; tick("cancel_release");

    speed = 8'd200; speed_valid = 1'b1; set_btn = 1'b1; tick("set_too_fast");
    tick("idle_a");
    speed = 8'd100; set_btn = 1'b1; tick("set_no_valid");
    tick("idle_b");
    brake = 1'b1; speed = 8'd60; speed_valid = 1'b1; set_btn = 1'b1; tick("set_braking");
    brake = 1'b0; tick("idle_c");

    latch(8'd100, "set100c");
    for (int i = 2; i <= 254; i++) tick("no_timeout_yet");
    drop_target(); e_flt = 1'b1;
    tick("timeout");
    latch(8'd60, "set_after_fault");
    e_st = 3'd3; sample(8'd50, "accel50");

    @(posedge clk); #2;
    rst_n = 1'b0;
    e_st = 3'd0; e_tgt = 8'd0; e_tv = 1'b0; e_flt = 1'b0;
    push("async_reset", cyc);
    @(negedge clk);
    tick("reset_held");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
